cpu5_lsu: RTL
=============

# cpu5_lsu

Load/store unit placed directly downstream of the cpu5 datapath's data-memory port. It receives the computed data address and store data, runs a valid/ready transaction on the data bus, and returns extracted, sign/zero-extended load data. It also stalls the core until the access completes. It replaces the datapath's direct single-cycle connection to data memory with sized (byte/half/word) accesses and byte strobes.

## Interface
- `XLEN`, default 32: data and address width. Only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lsu_req`  in  1  access request. Held high by the core, with all request fields stable, until the cycle `lsu_done`=1.
- `lsu_we`  in  1  1 = store, 0 = load.
- `lsu_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `lsu_unsigned`  in  1  zero-extend the load result (LBU/LHU).
- `lsu_addr`  in  XLEN  byte address (the datapath's `dataaddr`).
- `lsu_wdata`  in  XLEN  store data (the datapath's `writedata`).
- `lsu_stall`  out  1  freezes the PC and register writeback.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_rdata`  out  XLEN  extended load data. Valid when `lsu_done`=1 and `lsu_we`=0.
- `lsu_misalign`  out  1  misaligned access. Valid with `lsu_done`.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus accept/complete.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  XLEN  word-aligned address; bits [1:0] are always 0.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0000 for loads.
- `mem_rdata`  in  XLEN  read word, sampled on the `mem_valid & mem_ready` cycle.

## Operation
- The FSM has three states: IDLE, BUS, RESP.
- **IDLE**
  - If `lsu_req`=1 and the access is not flagged misaligned:
    - latch the request into `mem_addr`/`mem_we`/`mem_wdata`/`mem_wstrb` and the size, unsigned and byte-offset registers;
    - go to BUS.
  - If `lsu_req`=1 and the access is flagged misaligned: go to RESP with the misalign flag set.
- **BUS**
  - `mem_valid`=1.
  - On `mem_ready`=1: capture `mem_rdata` and go to RESP.
  - Otherwise stay in BUS, holding all `mem_*` outputs stable.
- **RESP**
  - `lsu_done`=1, `lsu_rdata` driven, then go to IDLE unconditionally.
  - The core's next request is seen no earlier than the following cycle.
- `lsu_stall = lsu_req & (state != RESP)`. This is combinational, so it is high during the request cycle in IDLE.
- **Store lanes**
  - byte: `mem_wdata = {4{wdata[7:0]}}`, `mem_wstrb = 0001 << addr[1:0]`;
  - half: `{2{wdata[15:0]}}`, strobes 0011 (`addr[1]`=0) or 1100 (`addr[1]`=1);
  - word: `wdata`, strobes 1111.
- **Load extraction**
  - byte: lane selected by `addr[1:0]`;
  - half: lane selected by `addr[1]`;
  - word: the whole word.
  - Sign-extend from bit 7/15 unless `lsu_unsigned`=1, in which case zero-extend.
- `lsu_rdata` is 0 outside RESP, in RESP for stores, and in RESP for misaligned accesses.
- **Reset**
  - state IDLE.
  - All outputs 0: `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `lsu_done`, `lsu_rdata`, `lsu_misalign`.
  - `lsu_stall` follows its equation.
- **Reset mid-operation**: reset during BUS drops `mem_valid` at that edge and the transaction is abandoned. The bus must tolerate a withdrawn request.

## Timing
- Zero-wait access takes 3 cycles from `lsu_req` rising:
  - cycle 0: IDLE, latch;
  - cycle 1: BUS, `mem_valid`=1, `mem_ready`=1;
  - cycle 2: RESP, `lsu_done`=1, `lsu_stall`=0.
- Each wait cycle (`mem_ready`=0 in BUS) adds exactly one cycle.
- A misaligned access, when checking is enabled, takes 2 cycles: IDLE → RESP, with no bus activity.
- `mem_valid` never deasserts before `mem_ready` except on reset.
- Back-to-back requests: minimum one IDLE cycle between RESP and the next BUS.

## Configuration
- `CPU5_LSU_MISALIGN_CHECK_EN` defined:
  - misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0;
  - a misaligned access issues no bus transaction and gives `lsu_misalign`=1 with `lsu_done`.
- Undefined:
  - `lsu_misalign` is tied 0;
  - the offending low address bits are forced to 0 (half ignores `addr[0]`, word ignores `addr[1:0]`) and the access proceeds normally.

## Test plan
- **SW, no wait**: `lsu_addr`=0x104, `lsu_wdata`=0xDEADBEEF, `mem_ready`=1 → cycle 1 shows `mem_addr`=0x104, `mem_wstrb`=1111, `mem_wdata`=0xDEADBEEF; cycle 2 shows `lsu_done`=1.
- **LB/LBU**: `lsu_addr`=0x103, `mem_rdata`=0x80112233 → LB gives `lsu_rdata`=0xFFFFFF80; LBU gives 0x00000080.
- **SH**: `lsu_addr`=0x106, `lsu_wdata`=0x1234ABCD → `mem_addr`=0x104, `mem_wdata`=0xABCDABCD, `mem_wstrb`=1100. LH at 0x106 with `mem_rdata`=0x8001FFFF → `lsu_rdata`=0xFFFF8001.
- **Wait states**: `mem_ready` low for 3 BUS cycles → all `mem_*` outputs stable and `lsu_stall`=1 throughout; `lsu_done` arrives one cycle after `mem_ready`, 6 cycles total.
- **Misaligned LW** at 0x102:
  - with the macro: `mem_valid` is never asserted; cycle 1 shows `lsu_done`=1, `lsu_misalign`=1, `lsu_rdata`=0;
  - without the macro: the access goes to `mem_addr`=0x100.
- **Reset mid-transaction**: `reset` asserted in BUS → next cycle state is IDLE with `mem_valid`=0 and all outputs 0; a fresh LW at 0x200 then completes normally.

Source files
------------

// File: rtl/cpu5_lsu.sv
// cpu5_lsu: load/store unit. Sized, strobed valid/ready bus accesses with sign/zero-extended loads.
// Optional macro CPU5_LSU_MISALIGN_CHECK_EN enables misaligned-access detection. Revision 1.0
`default_nettype none

module cpu5_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misalign,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [1:0]      off_q;

  logic            misalign_req;
  logic [3:0]      wstrb_n;
  logic [XLEN-1:0] wdata_n;
  logic [1:0]      off_n;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_ext;

`ifdef CPU5_LSU_MISALIGN_CHECK_EN
  assign misalign_req = ((lsu_size == 2'b01) & lsu_addr[0]) |
                        (lsu_size[1] & (lsu_addr[1:0] != 2'b00));
`else
  assign misalign_req = 1'b0;
`endif

  assign lsu_stall = lsu_req & (state != S_RESP);

  // Offsets drop the low bits a half/word cannot use, which also realigns
  // unchecked misaligned accesses.
  always_comb begin
    wstrb_n = 4'b1111;
    wdata_n = lsu_wdata;
    off_n   = 2'b00;
    case (lsu_size)
      2'b00: begin
        wstrb_n = 4'b0001 << lsu_addr[1:0];
        wdata_n = {4{lsu_wdata[7:0]}};
        off_n   = lsu_addr[1:0];
      end
      2'b01: begin
        wstrb_n = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{lsu_wdata[15:0]}};
        off_n   = {lsu_addr[1], 1'b0};
      end
      default: ;
    endcase
    if (!lsu_we) wstrb_n = 4'b0000;
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){~unsigned_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{(XLEN-16){~unsigned_q & rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= 4'b0000;
      lsu_done     <= 1'b0;
      lsu_rdata    <= '0;
      lsu_misalign <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req) begin
            if (misalign_req) begin
              lsu_done     <= 1'b1;
              lsu_misalign <= 1'b1;
              state        <= S_RESP;
            end else begin
              mem_valid  <= 1'b1;
              mem_we     <= lsu_we;
              mem_addr   <= {lsu_addr[XLEN-1:2], 2'b00};
              mem_wdata  <= wdata_n;
              mem_wstrb  <= wstrb_n;
              size_q     <= lsu_size;
              unsigned_q <= lsu_unsigned;
              off_q      <= off_n;
              state      <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            lsu_done  <= 1'b1;
            lsu_rdata <= mem_we ? '0 : load_ext;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          lsu_done     <= 1'b0;
          lsu_rdata    <= '0;
          lsu_misalign <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
